// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES round sequencer: FSM states,
// key-length codes, round-count lookup and the round-constant table.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL,
        ST_HOLD
    } seq_state_e;

    localparam logic [1:0] KEYLEN_128 = 2'b00;
    localparam logic [1:0] KEYLEN_192 = 2'b01;
    localparam logic [1:0] KEYLEN_256 = 2'b10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
    };

    // Illegal code 11 never reaches this lookup (the block is rejected).
    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KEYLEN_192: nr_of = 4'd12;
            KEYLEN_256: nr_of = 4'd14;
            default:    nr_of = 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        rcon_of = 8'h00;
        if (idx >= 4'd1 && idx <= 4'd10) begin
            rcon_of = RCON[idx];
        end
    endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Sub-cycle counter and up/down round index counter for the AES sequencer.
// Exposes next-cycle values so the parent can register its decoded outputs.
module aes_round_counter
    import aes_seq_pkg::*;
#(
    parameter int ROUND_CYCLES = 1,
    parameter int RIDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              step,
    input  logic              tick,
    input  logic              down,
    input  logic [RIDX_W-1:0] load_idx,
    input  logic [RIDX_W-1:0] nr,
    output logic [RIDX_W-1:0] round_idx,
    output logic [RIDX_W-1:0] idx_next,
    output logic              sub_last,
    output logic              sub_last_next,
    output logic              round_tc
);

    localparam int SUB_W = 2;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(ROUND_CYCLES - 1);

    logic [SUB_W-1:0]  sub_reg;
    logic [SUB_W-1:0]  sub_next;
    logic [RIDX_W-1:0] idx_reg;

    always_comb begin
        sub_next = sub_reg;
        idx_next = idx_reg;
        if (clr) begin
            sub_next = '0;
            idx_next = '0;
        end else if (load) begin
            sub_next = '0;
            idx_next = load_idx;
        end else begin
            if (tick) begin
                sub_next = sub_last ? '0 : sub_reg + SUB_W'(1);
            end
            if (step) begin
                idx_next = down ? idx_reg - RIDX_W'(1) : idx_reg + RIDX_W'(1);
            end
        end
    end

    assign sub_last      = (sub_reg == SUB_MAX);
    assign sub_last_next = (sub_next == SUB_MAX);
    // Last middle round: Nr-1 going up, 1 going down.
    assign round_tc      = down ? (idx_reg == RIDX_W'(1)) : (idx_reg == nr - RIDX_W'(1));
    assign round_idx     = idx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_reg <= '0;
            idx_reg <= '0;
        end else begin
            sub_reg <= sub_next;
            idx_reg <= idx_next;
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM for an iterative AES round datapath: accepts a block, walks
// the round schedule for AES-128/192/256 enc/dec, then holds the result.
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int ROUND_CYCLES = 1,
    parameter int RIDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        key_len,
    input  logic              decrypt,
    input  logic              abort,
    output logic              ld_state,
    output logic              ld_key,
    output logic              round_en,
    output logic              first_round,
    output logic              last_round,
    output logic [RIDX_W-1:0] round_idx,
    output logic [7:0]        rcon,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_keylen
);

    seq_state_e        state_reg, state_next;
    logic [RIDX_W-1:0] nr_reg;
    logic              dec_reg;
    logic [RIDX_W-1:0] idx_next;
    logic [RIDX_W-1:0] load_idx;
    logic              key_ok, accept;
    logic              sub_last, sub_last_next, round_tc;
    logic              cnt_clr, cnt_step, cnt_tick;

    logic              round_en_reg, first_round_reg, last_round_reg;
    logic              busy_reg, out_valid_reg, err_keylen_reg;
    logic [7:0]        rcon_reg;

    // Gated by rst_n so nothing is offered while the sequencer is held in reset.
    assign in_ready = rst_n & ((state_reg == ST_IDLE) | ((state_reg == ST_HOLD) & out_ready));
    assign key_ok   = (key_len != 2'b11);
    assign accept   = in_valid & in_ready & ~abort;
    assign ld_state = accept & key_ok;
    assign ld_key   = ld_state;
    assign load_idx = decrypt ? RIDX_W'(nr_of(key_len)) : '0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (ld_state) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_ROUND;
            ST_ROUND: if (sub_last && round_tc) state_next = ST_FINAL;
            ST_FINAL: if (sub_last) state_next = ST_HOLD;
            ST_HOLD:  if (out_ready) state_next = ld_state ? ST_LOAD : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    // LOAD is a single cycle regardless of ROUND_CYCLES, so it steps immediately.
    assign cnt_clr  = (state_next == ST_IDLE);
    assign cnt_step = (state_reg == ST_LOAD) | ((state_reg == ST_ROUND) & sub_last);
    assign cnt_tick = (state_reg == ST_ROUND) | (state_reg == ST_FINAL);

    aes_round_counter #(
        .ROUND_CYCLES (ROUND_CYCLES),
        .RIDX_W       (RIDX_W)
    ) u_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (cnt_clr),
        .load          (ld_state),
        .step          (cnt_step),
        .tick          (cnt_tick),
        .down          (dec_reg),
        .load_idx      (load_idx),
        .nr            (nr_reg),
        .round_idx     (round_idx),
        .idx_next      (idx_next),
        .sub_last      (sub_last),
        .sub_last_next (sub_last_next),
        .round_tc      (round_tc)
    );

    // Outputs are decoded from the next state so they leave flops directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            nr_reg          <= '0;
            dec_reg         <= 1'b0;
            round_en_reg    <= 1'b0;
            first_round_reg <= 1'b0;
            last_round_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            out_valid_reg   <= 1'b0;
            err_keylen_reg  <= 1'b0;
            rcon_reg        <= 8'h00;
        end else begin
            state_reg <= state_next;
            if (ld_state) begin
                nr_reg  <= RIDX_W'(nr_of(key_len));
                dec_reg <= decrypt;
            end
            round_en_reg    <= (state_next == ST_LOAD) |
                               (((state_next == ST_ROUND) | (state_next == ST_FINAL)) & sub_last_next);
            first_round_reg <= (state_next == ST_LOAD);
            last_round_reg  <= (state_next == ST_FINAL);
            busy_reg        <= (state_next == ST_LOAD) | (state_next == ST_ROUND) |
                               (state_next == ST_FINAL);
            out_valid_reg   <= (state_next == ST_HOLD);
            err_keylen_reg  <= accept & ~key_ok;
            rcon_reg        <= rcon_of(idx_next[3:0]);
        end
    end

    assign round_en    = round_en_reg;
    assign first_round = first_round_reg;
    assign last_round  = last_round_reg;
    assign busy        = busy_reg;
    assign out_valid   = out_valid_reg;
    assign err_keylen  = err_keylen_reg;
    assign rcon        = rcon_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: two instances (1 and 2 clocks per round)
// share stimulus and are checked every cycle against a schedule-based model.
module tb_aes_round_sequencer;

    localparam int RIDX_W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] key_len = 2'b00;
    logic       decrypt = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;

    logic              in_ready_o [2];
    logic              ld_state_o [2];
    logic              ld_key_o [2];
    logic              round_en_o [2];
    logic              first_o [2];
    logic              last_o [2];
    logic [RIDX_W-1:0] idx_o [2];
    logic [7:0]        rcon_o [2];
    logic              busy_o [2];
    logic              out_valid_o [2];
    logic              err_o [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        aes_round_sequencer #(
            .ROUND_CYCLES (gi + 1),
            .RIDX_W       (RIDX_W)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (in_valid),
            .in_ready    (in_ready_o[gi]),
            .key_len     (key_len),
            .decrypt     (decrypt),
            .abort       (abort),
            .ld_state    (ld_state_o[gi]),
            .ld_key      (ld_key_o[gi]),
            .round_en    (round_en_o[gi]),
            .first_round (first_o[gi]),
            .last_round  (last_o[gi]),
            .round_idx   (idx_o[gi]),
            .rcon        (rcon_o[gi]),
            .busy        (busy_o[gi]),
            .out_valid   (out_valid_o[gi]),
            .out_ready   (out_ready),
            .err_keylen  (err_o[gi])
        );
    end

    // Reference model: a block in flight is described only by how many
    // cycles have passed since it was accepted (k=1 is the load cycle).
    bit m_active [2];
    int m_k [2];
    int m_nr [2];
    bit m_dec [2];
    bit m_err [2];

    typedef struct packed {
        bit in_ready;
        bit ld;
        bit round_en;
        bit first;
        bit last;
        bit busy;
        bit out_valid;
        bit err;
        bit idx_valid;
        int idx;
        int rcon;
    } exp_t;

    function automatic int rcon_ref(int idx);
        int r;
        if (idx < 1 || idx > 10) return 0;
        r = 1;
        for (int n = 1; n < idx; n++) begin
            r = (r << 1) ^ (((r & 'h80) != 0) ? 'h11b : 0);
        end
        return r;
    endfunction

    function automatic exp_t model_exp(int i);
        exp_t e;
        int rc, j, last_busy;
        rc = i + 1;
        e = '0;
        e.idx_valid = 1'b1;
        if (!rst_n) return e;
        if (!m_active[i]) begin
            e.in_ready = 1'b1;
        end else begin
            last_busy = 1 + m_nr[i] * rc;
            if (m_k[i] > last_busy) begin
                e.out_valid = 1'b1;
                e.in_ready  = out_ready;
                e.idx_valid = 1'b0;
            end else begin
                e.busy = 1'b1;
                if (m_k[i] == 1) begin
                    e.first    = 1'b1;
                    e.round_en = 1'b1;
                    e.idx      = m_dec[i] ? m_nr[i] : 0;
                end else if (m_k[i] <= 1 + (m_nr[i] - 1) * rc) begin
                    j = m_k[i] - 2;
                    e.idx      = m_dec[i] ? (m_nr[i] - 1 - j / rc) : (1 + j / rc);
                    e.round_en = ((j % rc) == rc - 1);
                end else begin
                    j = m_k[i] - 2 - (m_nr[i] - 1) * rc;
                    e.idx      = m_dec[i] ? 0 : m_nr[i];
                    e.last     = 1'b1;
                    e.round_en = (j == rc - 1);
                end
            end
        end
        e.rcon = rcon_ref(e.idx);
        e.ld   = in_valid && e.in_ready && !abort && (key_len != 2'b11);
        e.err  = m_err[i];
        return e;
    endfunction

    task automatic model_update(int i);
        exp_t e;
        bit acc;
        e = model_exp(i);
        acc = in_valid && e.in_ready && !abort;
        m_err[i] = acc && (key_len == 2'b11);
        if (abort) begin
            m_active[i] = 1'b0;
        end else if (acc && key_len != 2'b11) begin
            m_active[i] = 1'b1;
            m_k[i]      = 1;
            m_nr[i]     = 10 + 2 * int'(key_len);
            m_dec[i]    = decrypt;
        end else if (m_active[i] && e.out_valid && out_ready) begin
            m_active[i] = 1'b0;
        end else if (m_active[i]) begin
            m_k[i]++;
        end
    endtask

    task automatic check(string name, int i, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d expected=%0d", name, i, cyc, act, exp);
        end
    endtask

    task automatic check_all(int i);
        exp_t e;
        e = model_exp(i);
        check("in_ready", i, int'(in_ready_o[i]), int'(e.in_ready));
        check("ld_state", i, int'(ld_state_o[i]), int'(e.ld));
        check("ld_key", i, int'(ld_key_o[i]), int'(e.ld));
        check("round_en", i, int'(round_en_o[i]), int'(e.round_en));
        check("first_round", i, int'(first_o[i]), int'(e.first));
        check("last_round", i, int'(last_o[i]), int'(e.last));
        check("busy", i, int'(busy_o[i]), int'(e.busy));
        check("out_valid", i, int'(out_valid_o[i]), int'(e.out_valid));
        check("err_keylen", i, int'(err_o[i]), int'(e.err));
        if (e.idx_valid) begin
            check("round_idx", i, int'(idx_o[i]), e.idx);
            check("rcon", i, int'(rcon_o[i]), e.rcon);
        end
        if (e.out_valid && out_ready) begin
            $display("txn dut%0d block done cyc=%0d nr=%0d dec=%0d", i, cyc, m_nr[i], m_dec[i]);
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) check_all(i);
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) model_update(i);
        end
        cyc++;
        #1;
    endtask

    typedef struct {
        logic [1:0] kl;
        bit         dec;
        int         lat1;
        int         lat2;
        bit         err;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int lat [2];

        tbl[0] = '{2'd0, 1'b0, 12, 22, 1'b0};
        tbl[1] = '{2'd0, 1'b1, 12, 22, 1'b0};
        tbl[2] = '{2'd1, 1'b0, 14, 26, 1'b0};
        tbl[3] = '{2'd1, 1'b1, 14, 26, 1'b0};
        tbl[4] = '{2'd2, 1'b1, 16, 30, 1'b0};
        tbl[5] = '{2'd3, 1'b0, 0, 0, 1'b1};

        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_err[i]    = 1'b0;
            m_k[i]      = 0;
            m_nr[i]     = 10;
            m_dec[i]    = 1'b0;
        end

        // Reset state
        step();
        step();
        rst_n = 1'b1;
        step();

        // Table-driven single blocks, consumer always ready
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            key_len  = tbl[v].kl;
            decrypt  = tbl[v].dec;
            in_valid = 1'b1;
            #1;
            for (int i = 0; i < 2; i++) begin
                check("vec_ld_state", i, int'(ld_state_o[i]), int'(!tbl[v].err));
            end
            t0 = cyc;
            lat[0] = 0;
            lat[1] = 0;
            step();
            in_valid = 1'b0;
            for (int c = 0; c < 40; c++) begin
                for (int i = 0; i < 2; i++) begin
                    if (lat[i] == 0 && out_valid_o[i]) lat[i] = cyc - t0;
                    if (c == 0) begin
                        check("vec_err_pulse", i, int'(err_o[i]), int'(tbl[v].err));
                        if (tbl[v].err) check("vec_keylen_in_ready", i, int'(in_ready_o[i]), 1);
                    end
                end
                step();
            end
            check("vec_latency", 0, lat[0], tbl[v].lat1);
            check("vec_latency", 1, lat[1], tbl[v].lat2);
            $display("vec %0d key_len=%0d dec=%0d lat_rc1=%0d lat_rc2=%0d", v, tbl[v].kl, tbl[v].dec,
                     lat[0], lat[1]);
        end

        // Back-to-back: in_valid held, result held until consumer ready
        key_len   = 2'd0;
        decrypt   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!(out_valid_o[0] && out_valid_o[1]) && n < 60) begin
            step();
            n++;
        end
        check("b2b_reach_hold", 1, int'(out_valid_o[1]), 1);
        for (int c = 0; c < 3; c++) begin
            check("ov_stable", 0, int'(out_valid_o[0]), 1);
            step();
        end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) check("b2b_ld_state", i, int'(ld_state_o[i]), 1);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("b2b_first_round", i, int'(first_o[i]), 1);
            check("b2b_ov_drop", i, int'(out_valid_o[i]), 0);
        end
        out_ready = 1'b1;
        repeat (40) step();

        // Abort in the middle of round 5
        key_len  = 2'd0;
        decrypt  = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (idx_o[0] != 4'd5 && n < 20) begin
            step();
            n++;
        end
        check("abort_reach_r5", 0, int'(idx_o[0]), 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("abort_busy", i, int'(busy_o[i]), 0);
            check("abort_idx", i, int'(idx_o[i]), 0);
            check("abort_out_valid", i, int'(out_valid_o[i]), 0);
            check("abort_in_ready", i, int'(in_ready_o[i]), 1);
        end
        key_len  = 2'd2;
        decrypt  = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (35) step();

        // Asynchronous reset during the final round
        key_len   = 2'd0;
        decrypt   = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!last_o[0] && n < 20) begin
            step();
            n++;
        end
        check("rst_reach_final", 0, int'(last_o[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_in_ready", i, int'(in_ready_o[i]), 0);
            check("rst_round_en", i, int'(round_en_o[i]), 0);
            check("rst_first", i, int'(first_o[i]), 0);
            check("rst_last", i, int'(last_o[i]), 0);
            check("rst_idx", i, int'(idx_o[i]), 0);
            check("rst_rcon", i, int'(rcon_o[i]), 0);
            check("rst_busy", i, int'(busy_o[i]), 0);
            check("rst_out_valid", i, int'(out_valid_o[i]), 0);
            check("rst_err", i, int'(err_o[i]), 0);
            m_active[i] = 1'b0;
            m_err[i]    = 1'b0;
        end
        #3 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) check("rst_release_in_ready", i, int'(in_ready_o[i]), 1);
        step();

        // Randomised traffic against the model
        for (int c = 0; c < 800; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            key_len   = 2'($urandom_range(0, 3));
            decrypt   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            abort     = ($urandom_range(0, 49) == 0);
            step();
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
